bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and transfer sequencer for the shared 8-bit crypto data bus. Up to four modules (bus IDs 0–3) request the bus with a target destination ID. The arbiter grants one source at a time, drives the source and destination IDs, and routes the valid/ready handshake between the granted source and its destination. It holds the grant until the burst ends, then releases the bus. It also forces release on a burst-length cap, a requester abort, or a stalled transfer, so no module can hold the bus indefinitely.

## Interface
Parameters:
- MAX_BEATS, 32: maximum beats per grant before a forced release (range 2–255).
- TIMEOUT, 16: consecutive stalled XFER cycles before a forced release (range 2–255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  req[i]=1: module i requests the bus.
- req_dest  in  8  req_dest[2i+1:2i] is the destination ID of requester i.
- src_valid  in  4  per-source valid; src_valid[i] qualifies module i's byte on the bus.
- src_last  in  4  per-source last-beat flag; meaningful only with src_valid.
- dst_ready  in  4  per-destination ready.
- grant  out  4  one-hot, registered; ack to the granted source.
- bus_src_id  out  2  registered ID of the granted source.
- bus_dst_id  out  2  registered destination ID of the current grant.
- dst_sel  out  4  one-hot, registered; tells the destination to sample the bus.
- bus_valid  out  1  combinational: src_valid[granted] while in XFER, else 0.
- bus_ready  out  1  combinational: dst_ready[bus_dst_id] while in XFER, else 0.
- busy  out  1  registered; 1 while in XFER.
- timeout_err  out  1  registered 1-cycle pulse on a stall-timeout release.
- self_err  out  1  registered 1-cycle pulse when a self-addressed request is skipped.

## Operation
- States: IDLE and XFER.
- beat = bus_valid && bus_ready, evaluated in XFER only.
- Arbitration in IDLE:
  - The requester set is req[i] with req_dest(i) != i.
  - Search order starts at (ptr+1) mod 4 and wraps.
  - The first hit is registered into grant, bus_src_id, bus_dst_id and dst_sel; busy=1; state goes to XFER.
  - ptr is set to the winner. ptr resets to 3, so requester 0 has first priority.
- Self-addressed request: req[i]=1 with req_dest(i)==i is never granted.
  - self_err pulses in each IDLE cycle where the search skips such a requester.
  - No pulse if that requester would not have been reached.
- XFER bookkeeping:
  - beat_cnt (8-bit) increments on each beat.
  - stall_cnt (8-bit) increments on each cycle with no beat and clears on a beat.
  - Both counters clear on entry to XFER.
- XFER → IDLE at the next edge, with all grant outputs and busy cleared, when any of these hold (priority order, only the first applies):
  - beat with src_last[granted]=1 (normal end);
  - beat that makes beat_cnt == MAX_BEATS (fairness cap);
  - req[granted]==0 (abort; a beat in the same cycle still counts as delivered);
  - stall_cnt == TIMEOUT-1 with no beat this cycle, which also pulses timeout_err.
- Changes to req_dest during XFER are ignored. bus_dst_id is latched at grant.
- Release-to-grant gap: at least one IDLE cycle between consecutive grants, even for the same requester.

## Timing
- Reset: at the first edge with reset=1, all registered outputs go to 0. State=IDLE, ptr=3, counters=0. bus_valid and bus_ready follow to 0 combinationally.
- Reset mid-burst: the grant drops at that edge. Any beat in that cycle is not counted.
- Grant latency: req sampled at edge N (IDLE) → grant visible after edge N, so the first beat is possible in cycle N+1.
- Release latency: the terminating condition in cycle M → grant=0 and busy=0 after edge M.
  - IDLE runs in cycle M+1; the next grant is visible after edge M+1.
- Minimum grant duration is one cycle: a single-beat burst with last gives grant for exactly one cycle.
- bus_valid and bus_ready have zero-cycle latency from src_valid and dst_ready. There is no path from req to bus_valid.
- Simultaneous requests resolve in one IDLE cycle. No combinational loop through grant.

## Test plan
- Reset, then req=4'b0001, dest0=2, src_valid[0]=1, dst_ready[2]=1, last on the 3rd beat → grant=0001 for 3 cycles, bus_src_id=0, bus_dst_id=2, dst_sel=0100, 3 beats, then IDLE.
- req=4'b1111 held, every burst is 1 beat with last → grant order 0,1,2,3,0 with one IDLE cycle between each grant.
- Single requester with src_valid=1 and last never set, MAX_BEATS=32 → release after beat 32; re-grant 2 cycles later.
- Granted source holds src_valid=0, TIMEOUT=16 → release after 16 XFER cycles; timeout_err pulses exactly once.
- req=4'b0011 with dest1=1 (self) → requester 0 granted, self_err pulses when 1 is skipped; requester 1 is never granted.
- Assert reset during beat 2 of a 5-beat burst → all outputs 0 next cycle; after reset, requester 0 wins first.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and transfer sequencer
// for the shared 8-bit crypto data bus (four modules, IDs 0-3).
module bus_arbiter #(
    parameter int MAX_BEATS = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] req_dest,
    input  logic [3:0] src_valid,
    input  logic [3:0] src_last,
    input  logic [3:0] dst_ready,
    output logic [3:0] grant,
    output logic [1:0] bus_src_id,
    output logic [1:0] bus_dst_id,
    output logic [3:0] dst_sel,
    output logic       bus_valid,
    output logic       bus_ready,
    output logic       busy,
    output logic       timeout_err,
    output logic       self_err
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] beat_cnt;
    logic [7:0] stall_cnt;

    logic       hit;
    logic       skip;
    logic [1:0] win;
    logic [1:0] idx;
    logic [1:0] win_dest;

    logic       xfer;
    logic       beat;
    logic       end_last;
    logic       end_cap;
    logic       end_abort;
    logic       end_to;
    logic       done;

    // Round-robin search from ptr+1; note self-addressed requesters passed over
    always_comb begin
        hit  = 1'b0;
        skip = 1'b0;
        win  = 2'd0;
        idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!hit && req[idx]) begin
                if (req_dest[{idx, 1'b0} +: 2] == idx) begin
                    skip = 1'b1;
                end else begin
                    hit = 1'b1;
                    win = idx;
                end
            end
        end
        win_dest = req_dest[{win, 1'b0} +: 2];
    end

    assign xfer      = (state == XFER);
    assign bus_valid = xfer & src_valid[bus_src_id];
    assign bus_ready = xfer & dst_ready[bus_dst_id];
    assign beat      = bus_valid & bus_ready;

    assign end_last  = beat & src_last[bus_src_id];
    assign end_cap   = beat & ((beat_cnt + 8'd1) == 8'(MAX_BEATS));
    assign end_abort = ~req[bus_src_id];
    assign end_to    = ~beat & (stall_cnt == 8'(TIMEOUT - 1));
    assign done      = end_last | end_cap | end_abort | end_to;

    // Grant/release FSM with registered bus-control outputs and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            beat_cnt    <= 8'd0;
            stall_cnt   <= 8'd0;
            grant       <= 4'd0;
            bus_src_id  <= 2'd0;
            bus_dst_id  <= 2'd0;
            dst_sel     <= 4'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            self_err    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            self_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    self_err <= skip;
                    if (hit) begin
                        state      <= XFER;
                        ptr        <= win;
                        grant      <= 4'b0001 << win;
                        bus_src_id <= win;
                        bus_dst_id <= win_dest;
                        dst_sel    <= 4'b0001 << win_dest;
                        busy       <= 1'b1;
                        beat_cnt   <= 8'd0;
                        stall_cnt  <= 8'd0;
                    end
                end
                XFER: begin
                    if (done) begin
                        state       <= IDLE;
                        grant       <= 4'd0;
                        bus_src_id  <= 2'd0;
                        bus_dst_id  <= 2'd0;
                        dst_sel     <= 4'd0;
                        busy        <= 1'b0;
                        timeout_err <= end_to & ~(end_last | end_cap | end_abort);
                    end else if (beat) begin
                        beat_cnt  <= beat_cnt + 8'd1;
                        stall_cnt <= 8'd0;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with a
// transaction-level reference model and randomized traffic.
module tb_bus_arbiter;

    localparam int MAXB = 32;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] req_dest;
    logic [3:0] src_valid;
    logic [3:0] src_last;
    logic [3:0] dst_ready;
    logic [3:0] grant;
    logic [1:0] bus_src_id;
    logic [1:0] bus_dst_id;
    logic [3:0] dst_sel;
    logic       bus_valid;
    logic       bus_ready;
    logic       busy;
    logic       timeout_err;
    logic       self_err;

    bus_arbiter #(.MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dest(req_dest),
        .src_valid(src_valid), .src_last(src_last), .dst_ready(dst_ready),
        .grant(grant), .bus_src_id(bus_src_id), .bus_dst_id(bus_dst_id),
        .dst_sel(dst_sel), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .busy(busy), .timeout_err(timeout_err), .self_err(self_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] regs;
        int          owner;
        int          dst;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    int m_owner = -1;
    int m_dst   = 0;
    int m_last  = 3;
    int m_beats = 0;
    int m_stall = 0;

    bit   collect = 0;
    int   order[$];
    logic prev_busy = 1'b0;
    int   n_to = 0;
    int   n_self = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input int i);
        return int'(req_dest[2*i +: 2]);
    endfunction

    // Reference model: who owns the bus, how many beats/stalls so far
    always @(posedge clk) begin
        exp_t e;
        bit   skip;
        bit   dlv;
        bit   terr;
        int   win;
        int   i;
        skip = 0;
        terr = 0;
        win  = -1;
        if (reset) begin
            m_owner = -1;
            m_last  = 3;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                i = (m_last + k) % 4;
                if (win < 0 && req[i]) begin
                    if (dest_of(i) == i) skip = 1;
                    else win = i;
                end
            end
            if (win >= 0) begin
                m_owner = win;
                m_dst   = dest_of(win);
                m_last  = win;
                m_beats = 0;
                m_stall = 0;
            end
        end else begin
            dlv = src_valid[m_owner] && dst_ready[m_dst];
            if (dlv) begin
                m_beats++;
                m_stall = 0;
            end else begin
                m_stall++;
            end
            if ((dlv && src_last[m_owner]) || (dlv && m_beats == MAXB) ||
                !req[m_owner]) begin
                m_owner = -1;
            end else if (!dlv && m_stall == TMO) begin
                m_owner = -1;
                terr    = 1;
            end
        end
        if (m_owner >= 0)
            e.regs = {4'(1 << m_owner), 2'(m_owner), 2'(m_dst),
                      4'(1 << m_dst), 1'b1, terr, skip};
        else
            e.regs = {12'd0, terr, skip};
        e.owner = m_owner;
        e.dst   = m_dst;
        q.push_back(e);
    end

    // Monitor: pop expected state and compare registered and combinational outputs
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] cmb;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("regs", {grant, bus_src_id, bus_dst_id, dst_sel,
                         busy, timeout_err, self_err}, e.regs);
            cmb = (e.owner >= 0) ? {src_valid[e.owner], dst_ready[e.dst]} : 2'b00;
            chk("bus_vr", {bus_valid, bus_ready}, cmb);
        end
        if (collect && busy && !prev_busy) order.push_back(int'(bus_src_id));
        if (timeout_err) n_to++;
        if (self_err) n_self++;
        prev_busy <= busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req = 4'd0; req_dest = 8'd0;
        src_valid = 4'd0; src_last = 4'd0; dst_ready = 4'd0;
        step(3);
        reset = 1'b0;
        step(1);

        // 3-beat burst from 0 to 2
        req = 4'b0001; req_dest = 8'h02;
        src_valid = 4'b0001; dst_ready = 4'b0100;
        step(1);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_dsel", dst_sel, 4'b0100);
        step(2);
        src_last = 4'b0001;
        step(1);
        req = 4'd0; src_last = 4'd0;
        chk("t1_rel", busy, 1'b0);
        step(2);

        // all request, single-beat bursts: rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111; req_dest = 8'h39;
        src_valid = 4'b1111; dst_ready = 4'b1111; src_last = 4'b1111;
        order.delete();
        collect = 1;
        step(10);
        collect = 0;
        req = 4'd0;
        step(2);
        chk("t2_count", order.size(), 5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            chk("t2_order", order[k], k % 4);

        // fairness cap
        req = 4'b0001; req_dest = 8'h02;
        src_valid = 4'b0001; dst_ready = 4'b0100; src_last = 4'd0;
        step(40);
        req = 4'd0;
        step(2);

        // stall timeout
        n_to = 0;
        req = 4'b0001; src_valid = 4'd0;
        step(20);
        req = 4'd0;
        step(2);
        chk("t4_to_once", n_to, 1);

        // self-addressed requester 1
        n_self = 0;
        order.delete();
        req = 4'b0011; req_dest = 8'h06;
        src_valid = 4'b0011; dst_ready = 4'b1111; src_last = 4'b0011;
        collect = 1;
        step(12);
        collect = 0;
        req = 4'd0;
        step(2);
        chk("t5_self_seen", n_self > 0, 1'b1);
        for (int k = 0; k < order.size(); k++)
            chk("t5_not1", order[k] != 1, 1'b1);

        // reset in the middle of a burst
        req = 4'b0001; req_dest = 8'h02;
        src_valid = 4'b0001; dst_ready = 4'b0100; src_last = 4'd0;
        step(2);
        reset = 1'b1;
        step(1);
        chk("t6_rst_grant", grant, 4'd0);
        chk("t6_rst_busy", busy, 1'b0);
        reset = 1'b0;
        req = 4'b0011; req_dest = 8'h0E;
        step(1);
        chk("t6_first0", grant, 4'b0001);
        req = 4'd0;
        step(2);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom);
            if ($urandom_range(0, 7) == 0) req_dest = 8'($urandom);
            src_valid = 4'($urandom);
            dst_ready = 4'($urandom);
            src_last  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            step(1);
        end
        reset = 1'b0; req = 4'd0;
        src_valid = 4'd0; dst_ready = 4'd0; src_last = 4'd0;
        step(3);
        chk("drain", q.size() <= 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
